// File: rtl/div_unit.sv
// Multi-cycle restoring divider for the execute stage: quotient on lo, remainder on hi.
// Holds the pipeline via stall_div while iterating and presents the result for one cycle.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             annul,
  output logic             stall_div,
  output logic             ready,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] quot_reg, rem_reg, dvsr_reg;
  logic [WIDTH-1:0] hi_reg, lo_reg;
  logic             neg_q_reg, neg_r_reg;

  logic             a_neg, b_neg, last;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   shifted, diff;
  logic             q_bit;
  logic [WIDTH-1:0] rem_step, quot_step, lo_fix, hi_fix;

  // Operands are reduced to magnitudes; signs are reapplied on the final iteration.
  assign a_neg = signed_div & a[WIDTH-1];
  assign b_neg = signed_div & b[WIDTH-1];
  assign a_mag = a_neg ? (~a + 1'b1) : a;
  assign b_mag = b_neg ? (~b + 1'b1) : b;

  // The partial remainder stays below the divisor, so the top bit of diff is the borrow.
  assign shifted   = {rem_reg, quot_reg[WIDTH-1]};
  assign diff      = shifted - {1'b0, dvsr_reg};
  assign q_bit     = ~diff[WIDTH];
  assign rem_step  = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign quot_step = {quot_reg[WIDTH-2:0], q_bit};
  assign lo_fix    = neg_q_reg ? (~quot_step + 1'b1) : quot_step;
  assign hi_fix    = neg_r_reg ? (~rem_step + 1'b1) : rem_step;
  assign last      = (cnt_reg == CW'(WIDTH - 1));

  always_comb begin
    state_next = state_reg;
    stall_div  = 1'b0;
    ready      = 1'b0;
    case (state_reg)
      IDLE: begin
        stall_div = start & ~annul;
        if (start && !annul)
          state_next = (b == '0) ? DONE : BUSY;
      end
      BUSY: begin
        stall_div = ~annul;
        if (annul)
          state_next = IDLE;
        else if (last)
          state_next = DONE;
      end
      DONE: begin
        ready      = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      quot_reg  <= '0;
      rem_reg   <= '0;
      dvsr_reg  <= '0;
      neg_q_reg <= 1'b0;
      neg_r_reg <= 1'b0;
      hi_reg    <= '0;
      lo_reg    <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (start && !annul) begin
            if (b == '0) begin
              hi_reg <= a;
              lo_reg <= '1;
            end else begin
              quot_reg  <= a_mag;
              rem_reg   <= '0;
              dvsr_reg  <= b_mag;
              cnt_reg   <= '0;
              neg_q_reg <= signed_div & (a[WIDTH-1] ^ b[WIDTH-1]);
              neg_r_reg <= signed_div & a[WIDTH-1];
            end
          end
        end
        BUSY: begin
          if (!annul) begin
            quot_reg <= quot_step;
            rem_reg  <= rem_step;
            cnt_reg  <= cnt_reg + 1'b1;
            // Results land on the final iteration edge so they are valid throughout DONE.
            if (last) begin
              hi_reg <= hi_fix;
              lo_reg <= lo_fix;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign hi = hi_reg;
  assign lo = lo_reg;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: stimulus pushes expected {hi,lo}, a monitor pops on ready.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst, start, signed_div, annul;
  logic [31:0] a, b;
  logic        stall_div, ready;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;
  int pushes = 0;
  int ready_seen = 0;
  logic [63:0] exp_q[$];

  div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_div(signed_div),
    .a(a), .b(b), .annul(annul),
    .stall_div(stall_div), .ready(ready), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every ready pulse must match the oldest outstanding expectation.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (ready) begin
        ready_seen++;
        check("stall_in_done", {31'd0, stall_div}, 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_ready", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("hi", hi, e[63:32]);
          check("lo", lo, e[31:0]);
          $display("result: hi=0x%08h lo=0x%08h (expected hi=0x%08h lo=0x%08h)",
                   hi, lo, e[63:32], e[31:0]);
        end
      end
    end
  end

  // Issues a divide and holds start until stall drops; returns in the DONE cycle.
  task automatic do_div(input logic [31:0] x, input logic [31:0] y, input logic s,
                        input logic [31:0] eh, input logic [31:0] el, input int exp_stall);
    int n;
    exp_q.push_back({eh, el});
    pushes++;
    @(negedge clk);
    start = 1'b1; signed_div = s; a = x; b = y; annul = 1'b0;
    n = 0;
    #1;
    while (stall_div && n < 100) begin
      n++;
      @(negedge clk);
      #1;
    end
    check("stall_cycles", n, exp_stall);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start = 1'b0; annul = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded its time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; start = 1'b0; signed_div = 1'b0; annul = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_ready", {31'd0, ready}, 32'd0);
    check("reset_stall", {31'd0, stall_div}, 32'd0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Unsigned and signed basics.
    do_div(32'd100, 32'd7, 1'b0, 32'd2, 32'd14, 33);
    idle_cycles(1);
    do_div(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
    idle_cycles(1);
    do_div(32'd7, 32'hFFFF_FFFE, 1'b1, 32'd1, 32'hFFFF_FFFD, 33);
    idle_cycles(1);
    do_div(32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFF, 32'd3, 33);
    idle_cycles(1);
    do_div(32'hFFFF_FFF9, 32'd2, 1'b0, 32'd1, 32'h7FFF_FFFC, 33);
    idle_cycles(1);
    do_div(32'hFFFF_FFFF, 32'h10, 1'b0, 32'hF, 32'h0FFF_FFFF, 33);
    idle_cycles(1);

    // Divide by zero, signed and unsigned.
    do_div(32'hFFFF_FFFB, 32'd0, 1'b1, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1);
    idle_cycles(1);
    do_div(32'h1234, 32'd0, 1'b0, 32'h1234, 32'hFFFF_FFFF, 1);
    idle_cycles(2);

    // Annul at BUSY iteration 10: no result, hi/lo keep the divide-by-zero values.
    @(negedge clk);
    start = 1'b1; signed_div = 1'b0; a = 32'd1000; b = 32'd3;
    repeat (11) @(negedge clk);
    annul = 1'b1;
    #1;
    check("annul_stall", {31'd0, stall_div}, 32'd0);
    @(negedge clk);
    start = 1'b0; annul = 1'b0;
    #1;
    check("annul_idle_stall", {31'd0, stall_div}, 32'd0);
    check("annul_hi_kept", hi, 32'h1234);
    check("annul_lo_kept", lo, 32'hFFFF_FFFF);
    idle_cycles(40);
    check("annul_hi_later", hi, 32'h1234);
    check("annul_lo_later", lo, 32'hFFFF_FFFF);

    // Reset at BUSY iteration 20.
    @(negedge clk);
    start = 1'b1; signed_div = 1'b0; a = 32'd999; b = 32'd9;
    repeat (21) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    #1;
    check("rst_mid_ready", {31'd0, ready}, 32'd0);
    check("rst_mid_stall", {31'd0, stall_div}, 32'd0);
    check("rst_mid_hi", hi, 32'd0);
    check("rst_mid_lo", lo, 32'd0);
    idle_cycles(1);
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0, 32'h8000_0000, 33);
    idle_cycles(1);

    // Start held through DONE, then back-to-back issues with no gap.
    do_div(32'd77, 32'd10, 1'b0, 32'd7, 32'd7, 33);
    do_div(32'd50, 32'd5, 1'b0, 32'd0, 32'd10, 33);
    do_div(32'h55, 32'd0, 1'b1, 32'h55, 32'hFFFF_FFFF, 1);
    idle_cycles(40);

    check("queue_empty", exp_q.size(), 32'd0);
    check("ready_pulses", ready_seen, pushes);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
